// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use stall, branch flush, mul/div start/done/timeout sequencing, memory freeze; perf counters built only with HAZARD_PERF_CNT_EN.
// Stall/flush/start are combinational in the same cycle; i_mem_wait freezes every stage and overrides all other requests.
module hazard_ctrl #(
    parameter int unsigned MC_TIMEOUT = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_branch_taken,
    input  logic        i_ex_mc_op,
    input  logic        i_mc_done,
    input  logic        i_mem_wait,
    output logic        o_pc_stall,
    output logic        o_if_id_stall,
    output logic        o_id_ex_stall,
    output logic        o_ex_mem_stall,
    output logic        o_mem_wb_stall,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_ex_mem_flush,
    output logic        o_mc_start,
    output logic        o_mc_timeout,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    typedef enum logic [1:0] {ST_RUN, ST_MC_WAIT, ST_MC_HOLD} state_t;

    localparam logic [7:0] TCNT_LAST = 8'(MC_TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_tcnt;
    logic        w_freeze;
    logic        w_load_use;
    logic        w_mc_start;
    logic        w_mc_busy;
    logic        w_timeout;

    assign w_freeze   = i_mem_wait;
    assign w_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                        ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));
    assign w_mc_start = (r_state == ST_RUN) && i_ex_mc_op && !w_freeze;
    // Timeout fires even when frozen: tcnt keeps counting through freezes.
    assign w_timeout  = (r_state == ST_MC_WAIT) && (r_tcnt == TCNT_LAST) && !i_mc_done;
    assign w_mc_busy  = (r_state == ST_MC_WAIT) && !i_mc_done && !w_timeout && !w_freeze;

    assign o_mc_start   = w_mc_start;
    assign o_mc_timeout = w_timeout;

    always_comb begin
        o_pc_stall     = 1'b0;
        o_if_id_stall  = 1'b0;
        o_id_ex_stall  = 1'b0;
        o_ex_mem_stall = 1'b0;
        o_mem_wb_stall = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        if (w_freeze) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_stall = 1'b1;
            o_mem_wb_stall = 1'b1;
        end else if (w_mc_start || w_mc_busy) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_stall  = 1'b1;
            o_ex_mem_flush = 1'b1;
        end else if ((r_state == ST_RUN) && i_ex_branch_taken) begin
            // A taken branch makes the ID instruction wrong-path, so load-use is moot.
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
        end else if ((r_state == ST_RUN) && w_load_use) begin
            o_pc_stall     = 1'b1;
            o_if_id_stall  = 1'b1;
            o_id_ex_flush  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
            r_tcnt  <= 8'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_mc_start) begin
                        r_state <= ST_MC_WAIT;
                        r_tcnt  <= 8'd0;
                    end
                end
                ST_MC_WAIT: begin
                    if (i_mc_done) begin
                        r_state <= w_freeze ? ST_MC_HOLD : ST_RUN;
                    end else if (w_timeout) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_tcnt  <= r_tcnt + 8'd1;
                    end
                end
                ST_MC_HOLD: begin
                    if (!w_freeze) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (o_pc_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (o_if_id_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;
`else
    assign o_stall_cycles = 32'd0;
    assign o_flush_count  = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32 core. Detects load-use hazards and taken-branch redirects. Sequences multi-cycle EX operations (mul/div) through a start/done handshake with a timeout, and freezes the whole pipeline while data memory is busy. It drives the stall (hold) and flush (bubble) enables of the PC and the four pipeline registers. It complements the forwarding logic, which covers every RAW case except load-use.

## Interface
Parameters:
- MC_TIMEOUT, 64: maximum MC_WAIT cycles without `i_mc_done` before abort; legal range 2..255.

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  core clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_id_rs1, i_id_rs2  in  5 each  source registers of the ID-stage instruction.
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- i_ex_mem_read  in  1  EX-stage instruction is a load.
- i_ex_rd  in  5  EX-stage destination register.
- i_ex_branch_taken  in  1  EX resolved a taken branch or jump.
- i_ex_mc_op  in  1  EX-stage instruction is a multi-cycle op.
- i_mc_done  in  1  single-cycle pulse; multi-cycle unit result valid.
- i_mem_wait  in  1  data memory not ready; freeze pipeline.
- o_pc_stall, o_if_id_stall, o_id_ex_stall, o_ex_mem_stall, o_mem_wb_stall  out  1 each  hold register.
- o_if_id_flush, o_id_ex_flush, o_ex_mem_flush  out  1 each  load bubble next edge.
- o_mc_start  out  1  one-cycle start pulse to the multi-cycle unit.
- o_mc_timeout  out  1  one-cycle pulse; multi-cycle op aborted.
- o_stall_cycles  out  32  performance counter (see Configuration).
- o_flush_count  out  32  performance counter (see Configuration).

## Operation
- The FSM has three states:
  - RUN (reset state).
  - MC_WAIT: op in flight.
  - MC_HOLD: done received while frozen.
- A 1-bit done latch is not used. MC_HOLD encodes that condition.
- An 8-bit timeout counter `tcnt` runs alongside the FSM.
- Priority, highest first: freeze > MC sequencing > branch flush > load-use.
- Freeze: `i_mem_wait`=1 sets all five stall outputs to 1 and all flushes to 0. This holds in any state. `o_mc_start` is suppressed.
- MC start: state RUN and `i_ex_mc_op` and not freeze. This asserts `o_mc_start`, `o_pc_stall`, `o_if_id_stall` and `o_id_ex_stall`. It also asserts `o_ex_mem_flush` (bubble into MEM). Next state is MC_WAIT with `tcnt`=0.
- MC_WAIT, not frozen, `i_mc_done`=0: drive the same stalls plus `o_ex_mem_flush`; `tcnt`++.
- MC_WAIT, `i_mc_done`=1, not frozen: all stalls released, so the op advances to MEM with its result. Next state is RUN.
- MC_WAIT, `i_mc_done`=1 while frozen: next state is MC_HOLD.
- MC_HOLD: the freeze outputs apply while `i_mem_wait`=1. Once it is 0, stalls are released and the next state is RUN.
- Timeout: in MC_WAIT with `tcnt` = MC_TIMEOUT-1 and no done, `o_mc_timeout` pulses. Stalls are released as for done, and the next state is RUN. `tcnt` counts frozen cycles too.
- Branch flush: state RUN, `i_ex_branch_taken`, not frozen. This asserts `o_if_id_flush` and `o_id_ex_flush`; no stalls.
- Load-use: state RUN, `i_ex_mem_read`, `i_ex_rd`≠0, and (`i_id_uses_rs1` and rs1==rd, or `i_id_uses_rs2` and rs2==rd).
  - Asserts `o_pc_stall`, `o_if_id_stall` and `o_id_ex_flush` for exactly one cycle. The EX load advances, so the condition self-clears.
- Branch taken together with load-use: flush only. The ID instruction is wrong-path, so no stall is asserted.
- Stall and flush are never both asserted on the same register.

## Timing
- All stall, flush and `o_mc_start` outputs are combinational from state plus inputs. They are valid in the same cycle and sampled by the pipeline at the next rising edge.
- The op enters EX at cycle 0, when `o_mc_start` is high. If `i_mc_done` arrives at cycle N (N≥1), the op leaves EX at the edge ending cycle N. Minimum occupancy is 2 cycles.
- `i_mc_done` at cycle 0 (same cycle as start) is ignored. The unit must not respond combinationally.
- `o_mc_timeout` is registered-state-derived. It is high for exactly one cycle, MC_TIMEOUT cycles after start.
- Reset (asserted at any time, including mid MC_WAIT): state=RUN, `tcnt`=0, counters=0. All outputs read 0 while `i_rst_n`=0, except those combinationally caused by inputs in RUN.
- An in-flight multi-cycle unit must be reset by the same `i_rst_n`.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `o_stall_cycles` increments on every cycle with `o_pc_stall`=1.
  - `o_flush_count` increments on every cycle with `o_if_id_flush`=1.
  - Both are 32-bit, wrap at 2^32-1 → 0, and reset to 0.
- `HAZARD_PERF_CNT_EN` undefined: both ports are tied to 32'd0 and no counter flops are built.

## Test plan
- Load-use: EX `lw x5`, ID `add x6,x5,x1`.
  - Expect exactly one cycle of `o_pc_stall`=`o_if_id_stall`=`o_id_ex_flush`=1, then 0.
  - Same case with `i_ex_rd`=0: no stall.
- Branch plus load-use in the same cycle → `o_if_id_flush`=`o_id_ex_flush`=1, `o_pc_stall`=0, `o_flush_count` +1.
- MC op with `i_mc_done` at cycle 5 → `o_mc_start` high at cycle 0 only. Stalls plus `o_ex_mem_flush` on cycles 0–4, released at cycle 5. `o_stall_cycles`=5.
- MC op with `i_mem_wait` high on cycles 3–7 and `i_mc_done` at cycle 4 → MC_HOLD. Stalls stay through cycle 7, released at cycle 8.
- MC_TIMEOUT=8, no done → `o_mc_timeout` pulse at cycle 8, state RUN at cycle 9.
- `i_rst_n` low mid MC_WAIT → state RUN, counters 0, no `o_mc_timeout`. A fresh MC op restarts from `tcnt`=0.
